// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: arbiter state type and round-robin pick helper shared by the SDRAM port arbiter
package sdram_arb_pkg;
  typedef enum logic {IDLE, WAIT} arb_state_t;
  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] grant;
  } rr_pick_t;
  // Sized for the widest supported arbiter (8 ports); n limits the search to the real ports.
  function automatic rr_pick_t rr_pick(input logic [7:0] pending, input logic [2:0] ptr, input int n);
    rr_pick_t r;
    logic [2:0] j;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      j = 3'((int'(ptr) + k) % n);
      if (k < n && r.grant == '0 && pending[j]) begin
        r.idx = j;
        r.grant[j] = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/sdram_arb_slot.sv
// sdram_arb_slot: one client's latched request, held until the arbiter retires it
module sdram_arb_slot #(
  parameter int AW = 21,
  parameter int DW = 16,
  parameter int MW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd,
  input  logic          wr,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic [MW-1:0] byte_en,
  output logic          pending,
  output logic          op_wr,
  output logic [AW-1:0] slot_addr,
  output logic [DW-1:0] slot_data,
  output logic [MW-1:0] slot_byte_en
);
  always_ff @(posedge clk)
    if (reset) begin
      pending <= 1'b0;
      op_wr <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
      slot_byte_en <= '0;
    end else if ((rd || wr) && !pending) begin
      pending <= 1'b1;
      op_wr <= wr;
      slot_addr <= addr;
      slot_data <= data;
      slot_byte_en <= byte_en;
    end else if (clr) begin
      pending <= 1'b0;
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin merge of NUM_PORTS client SDRAM ports onto one controller port
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS         = 4,
  parameter int PORT_ADDR_WIDTH   = 21,
  parameter int DATA_WIDTH        = 16,
  parameter int DQM_WIDTH         = 2,
  parameter int PORT_OUTPUT_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS*PORT_ADDR_WIDTH-1:0]   cl_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]        cl_data,
  input  logic [NUM_PORTS*DQM_WIDTH-1:0]         cl_byte_en,
  input  logic [NUM_PORTS-1:0]                   cl_wr,
  input  logic [NUM_PORTS-1:0]                   cl_rd,
  output logic [NUM_PORTS*PORT_OUTPUT_WIDTH-1:0] cl_q,
  output logic [NUM_PORTS-1:0]                   cl_available,
  output logic [NUM_PORTS-1:0]                   cl_ready,
  output logic [PORT_ADDR_WIDTH-1:0]             ct_addr,
  output logic [DATA_WIDTH-1:0]                  ct_data,
  output logic [DQM_WIDTH-1:0]                   ct_byte_en,
  output logic                                   ct_wr,
  output logic                                   ct_rd,
  input  logic [PORT_OUTPUT_WIDTH-1:0]           ct_q,
  input  logic                                   ct_available,
  input  logic                                   ct_ready
);
  localparam int IW = $clog2(NUM_PORTS);
  arb_state_t state;
  logic [NUM_PORTS-1:0] pending, op_wr, clr;
  logic [NUM_PORTS-1:0][PORT_ADDR_WIDTH-1:0] s_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0][DQM_WIDTH-1:0] s_byte_en;
  logic [NUM_PORTS-1:0][PORT_OUTPUT_WIDTH-1:0] q;
  logic [IW-1:0] owner, rr_ptr, gnt;
  logic owner_wr, found, done;
  rr_pick_t pick;
  always_comb begin
    pick = rr_pick(8'(pending), 3'(rr_ptr), NUM_PORTS);
    found = |pick.grant;
    gnt = IW'(pick.idx);
  end
  assign done = state == WAIT && ct_ready;
  assign cl_available = ~pending;
  assign cl_q = q;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    assign clr[i] = done && owner == IW'(i);
    sdram_arb_slot #(.AW(PORT_ADDR_WIDTH), .DW(DATA_WIDTH), .MW(DQM_WIDTH)) u_slot (
      .clk(clk),
      .reset(reset),
      .rd(cl_rd[i]),
      .wr(cl_wr[i]),
      .clr(clr[i]),
      .addr(cl_addr[i*PORT_ADDR_WIDTH +: PORT_ADDR_WIDTH]),
      .data(cl_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .byte_en(cl_byte_en[i*DQM_WIDTH +: DQM_WIDTH]),
      .pending(pending[i]),
      .op_wr(op_wr[i]),
      .slot_addr(s_addr[i]),
      .slot_data(s_data[i]),
      .slot_byte_en(s_byte_en[i])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      owner_wr <= 1'b0;
      ct_rd <= 1'b0;
      ct_wr <= 1'b0;
      ct_addr <= '0;
      ct_data <= '0;
      ct_byte_en <= '0;
      cl_ready <= '0;
      q <= '0;
    end else begin
      ct_rd <= 1'b0;
      ct_wr <= 1'b0;
      cl_ready <= '0;
      if (state == IDLE && ct_available && found) begin
        state <= WAIT;
        owner <= gnt;
        owner_wr <= op_wr[gnt];
        ct_addr <= s_addr[gnt];
        ct_data <= s_data[gnt];
        ct_byte_en <= s_byte_en[gnt];
        ct_wr <= op_wr[gnt];
        ct_rd <= ~op_wr[gnt];
      end else if (done) begin
        if (!owner_wr) q[owner] <= ct_q;
        cl_ready[owner] <= 1'b1;
        rr_ptr <= owner == IW'(NUM_PORTS - 1) ? '0 : owner + 1'b1;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized scoreboard bench against a transaction-level arbiter model
module tb_sdram_port_arbiter;
  localparam int N = 4, AW = 21, DW = 16, MW = 2, QW = 32;
  logic clk = 1'b0, reset = 1'b1;
  logic [N*AW-1:0] cl_addr = '0;
  logic [N*DW-1:0] cl_data = '0;
  logic [N*MW-1:0] cl_byte_en = '0;
  logic [N-1:0] cl_wr = '0, cl_rd = '0;
  logic [N*QW-1:0] cl_q;
  logic [N-1:0] cl_available, cl_ready;
  logic [AW-1:0] ct_addr;
  logic [DW-1:0] ct_data;
  logic [MW-1:0] ct_byte_en;
  logic ct_wr, ct_rd;
  logic [QW-1:0] ct_q = '0;
  logic ct_available = 1'b1, ct_ready = 1'b0;

  typedef struct {
    logic wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] be;
  } req_t;
  req_t slot [N];
  bit pend [N];
  int issue [N];
  logic [QW-1:0] last_q [N];
  logic [QW-1:0] expq [N][$];
  int vectors = 0, errors = 0, cyc = 0;
  int ptr = 0, owner = 0, cnt = 0, avail_ctl = 1, delay_cfg = -1;
  bit st = 0, rdy_prev = 0, rst_prev = 0, stray = 0;
  logic [AW-1:0] cmd_addr = '0;

  sdram_port_arbiter #(.NUM_PORTS(N), .PORT_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .DQM_WIDTH(MW), .PORT_OUTPUT_WIDTH(QW)) dut (
    .clk(clk), .reset(reset),
    .cl_addr(cl_addr), .cl_data(cl_data), .cl_byte_en(cl_byte_en),
    .cl_wr(cl_wr), .cl_rd(cl_rd), .cl_q(cl_q),
    .cl_available(cl_available), .cl_ready(cl_ready),
    .ct_addr(ct_addr), .ct_data(ct_data), .ct_byte_en(ct_byte_en),
    .ct_wr(ct_wr), .ct_rd(ct_rd), .ct_q(ct_q),
    .ct_available(ct_available), .ct_ready(ct_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller read data is a fixed function of the address, so expectations exist at request time.
  function automatic logic [QW-1:0] fq(input logic [AW-1:0] a);
    return a == 21'h00123 ? 32'hDEADBEEF : 32'(a) * 32'h9E3779B1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      expq[i].delete();
      last_q[i] = '0;
    end
    ptr = 0;
    st = 0;
    rdy_prev = 0;
    cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cl_rd = '0;
    cl_wr = '0;
  endtask

  // Drive one client request this cycle; the model accepts it only if the port is free.
  task automatic req(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [MW-1:0] be);
    logic [QW-1:0] q;
    cl_rd[p] = rd;
    cl_wr[p] = wr;
    cl_addr[p*AW +: AW] = a;
    cl_data[p*DW +: DW] = d;
    cl_byte_en[p*MW +: MW] = be;
    if (!pend[p] && (rd || wr)) begin
      pend[p] = 1;
      issue[p] = cyc;
      slot[p] = '{wr, a, d, be};
      q = wr ? last_q[p] : fq(a);
      last_q[p] = q;
      expq[p].push_back(q);
    end
  endtask

  // Monitor and controller responder: evaluated mid-cycle, away from the active edge.
  initial forever begin
    int p, j;
    bit cmd, go, ap, rdy;
    logic [N-1:0] exp_av, exp_rdy;
    @(negedge clk);
    if (reset) begin
      clear_model();
      ct_ready = 1'b0;
      rst_prev = 1;
    end else begin
      if (rst_prev) begin
        check("reset ct_cmd", {ct_rd, ct_wr}, 0);
        check("reset ct_addr", ct_addr, 0);
        check("reset ct_data", ct_data, 0);
        check("reset ct_byte_en", ct_byte_en, 0);
        check("reset cl_ready", cl_ready, 0);
        check("reset cl_available", cl_available, {N{1'b1}});
        for (int i = 0; i < N; i++) check($sformatf("reset cl_q[%0d]", i), cl_q[i*QW +: QW], 0);
      end
      rst_prev = 0;
      ap = ct_available;
      cmd = ct_rd | ct_wr;
      for (int i = 0; i < N; i++) exp_av[i] = !(pend[i] && issue[i] <= cyc - 1);
      check("cl_available", cl_available, exp_av);
      exp_rdy = '0;
      if (rdy_prev) exp_rdy[owner] = 1'b1;
      if ((exp_rdy | cl_ready) != '0) check("cl_ready", cl_ready, exp_rdy);
      for (int i = 0; i < N; i++)
        if (exp_rdy[i] && expq[i].size() > 0)
          check($sformatf("cl_q[%0d]", i), cl_q[i*QW +: QW], expq[i].pop_front());
      p = -1;
      for (int k = 0; k < N; k++) begin
        j = (ptr + k) % N;
        if (p < 0 && pend[j] && issue[j] <= cyc - 2) p = j;
      end
      go = !st && ap && p >= 0;
      if (cmd || go) check("ct_cmd", cmd, go);
      if (cmd && go) begin
        check("ct_addr", ct_addr, slot[p].addr);
        check("ct_data", ct_data, slot[p].data);
        check("ct_byte_en", ct_byte_en, slot[p].be);
        check("ct_op", {ct_wr, ct_rd}, slot[p].wr ? 2'b10 : 2'b01);
        owner = p;
        cmd_addr = slot[p].addr;
        cnt = delay_cfg >= 0 ? delay_cfg : int'($urandom_range(0, 3));
      end
      st = (cmd && go) || (st && !rdy_prev);
      if (st && !cmd) check("ct_addr hold", ct_addr, cmd_addr);
      rdy = 0;
      if (st && cnt == 0) begin
        rdy = 1;
        ct_q = fq(cmd_addr);
        pend[owner] = 0;
        ptr = (owner + 1) % N;
      end else begin
        if (st) cnt--;
        ct_q = $urandom;
      end
      ct_ready = rdy || (stray && !st);
      if (!st) stray = 0;
      rdy_prev = rdy;
      ct_available = avail_ctl == 2 ? ($urandom_range(0, 3) != 0) : (avail_ctl == 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int again [2];
    int total;
    again = '{0, 0};
    repeat (3) tick();
    reset = 0;
    // four simultaneous reads, then ports 0 and 1 re-request as soon as they free up
    delay_cfg = 3;
    tick();
    for (int p = 0; p < N; p++) req(p, 1, 0, AW'(21'h01000 + p), '0, '0);
    for (int k = 0; k < 40; k++) begin
      tick();
      for (int p = 0; p < 2; p++)
        if (!pend[p] && again[p] == 0) begin
          again[p] = 1;
          req(p, 0, 1, AW'(21'h02000 + p), DW'(16'h1111 * (p + 1)), 2'b11);
        end
    end
    delay_cfg = -1;
    tick();
    req(2, 1, 0, 21'h00123, '0, '0);
    repeat (8) tick();
    req(0, 0, 1, 21'h00abc, 16'h55AA, 2'b01);
    repeat (8) tick();
    // rd and wr together, then an ignored request while pending
    req(1, 1, 1, 21'h00777, 16'hA1B2, 2'b10);
    tick();
    req(1, 1, 0, 21'h00999, 16'h0000, 2'b11);
    repeat (10) tick();
    // controller unavailable while port 3 waits
    avail_ctl = 0;
    req(3, 1, 0, 21'h00333, '0, '0);
    repeat (10) tick();
    avail_ctl = 1;
    repeat (6) tick();
    // reset while a transaction is outstanding, then a stray completion
    delay_cfg = 30;
    req(1, 1, 0, 21'h00555, '0, '0);
    for (int k = 0; k < 10 && !st; k++) tick();
    check("reached WAIT before reset", st, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    stray = 1;
    repeat (5) tick();
    delay_cfg = -1;
    // randomized traffic with a flickering controller
    avail_ctl = 2;
    repeat (1500) begin
      tick();
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 9) < 3) begin
          int op;
          op = $urandom_range(0, 2);
          req(p, op != 1, op != 0, AW'($urandom), DW'($urandom), MW'($urandom));
        end
    end
    avail_ctl = 1;
    repeat (40) tick();
    total = 0;
    for (int p = 0; p < N; p++) total += expq[p].size();
    check("outstanding after drain", total, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
